// File: rtl/csr_encoder.sv
// csr_encoder: packs a row-major dense matrix stream into CSR value, column and row-pointer tables.
module csr_encoder #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 560,
    parameter int COLS   = 560,
    parameter int SP_AW  = 14,
    parameter int ROW_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din_data,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sp_we,
    output logic [SP_AW-1:0]  sp_addr,
    output logic [DATA_W-1:0] sp_data,
    output logic [31:0]       col_data,
    output logic              row_we,
    output logic [ROW_AW-1:0] row_addr,
    output logic [31:0]       row_data,
    output logic [SP_AW:0]    nnz,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, INIT, STREAM, DONE} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     col;
    logic [ROW_AW-1:0] row;
    logic              restart, accept, nz, wr, last_col;
    logic [SP_AW:0]    nnz_d;

    assign din_ready = state == STREAM;
    assign busy      = state == INIT || state == STREAM;
    assign done      = state == DONE;

    // nnz saturates at 2^SP_AW, so its top bit alone marks a full value RAM
    always_comb begin
        restart  = start && (state == IDLE || state == DONE);
        accept   = state == STREAM && din_valid;
        nz       = |din_data;
        wr       = accept && nz && !nnz[SP_AW];
        nnz_d    = nnz + (SP_AW+1)'(wr);
        last_col = col == CW'(COLS - 1);
        state_d  = restart ? INIT :
                   state == INIT ? STREAM :
                   (accept && last_col && row == ROW_AW'(ROWS - 1)) ? DONE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_we    <= 1'b0;
            sp_addr  <= '0;
            sp_data  <= '0;
            col_data <= '0;
            row_we   <= 1'b0;
            row_addr <= '0;
            row_data <= '0;
            nnz      <= '0;
            overflow <= 1'b0;
            row      <= '0;
            col      <= '0;
        end else begin
            sp_we  <= wr;
            row_we <= state == INIT || (accept && last_col);
            if (restart) begin
                nnz      <= '0;
                overflow <= 1'b0;
                row      <= '0;
                col      <= '0;
            end
            if (state == INIT) begin
                row_addr <= '0;
                row_data <= '0;
            end
            if (wr) begin
                sp_addr  <= nnz[SP_AW-1:0];
                sp_data  <= din_data;
                col_data <= 32'(col);
                nnz      <= nnz_d;
            end
            if (accept && nz && nnz[SP_AW]) overflow <= 1'b1;
            if (accept) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) begin
                    row      <= row + 1'b1;
                    row_addr <= row + 1'b1;
                    row_data <= 32'(nnz_d);
                end
            end
        end
    end
endmodule

// File: tb/tb_csr_encoder.sv
// tb_csr_encoder: directed 4x4 matrices with a write scoreboard; value RAM holds 4 entries.
module tb_csr_encoder;
    localparam int R = 4, C = 4, SA = 2, RA = 3;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, din_valid = 1'b0;
    logic [31:0] din_data = '0;
    logic        din_ready, sp_we, row_we, busy, done, overflow;
    logic [SA-1:0] sp_addr;
    logic [31:0] sp_data, col_data, row_data;
    logic [RA-1:0] row_addr;
    logic [SA:0] nnz;

    always #5 clk = ~clk;

    csr_encoder #(.DATA_W(32), .ROWS(R), .COLS(C), .SP_AW(SA), .ROW_AW(RA)) dut (
        .clk(clk), .rst(rst), .start(start), .din_data(din_data), .din_valid(din_valid),
        .din_ready(din_ready), .sp_we(sp_we), .sp_addr(sp_addr), .sp_data(sp_data),
        .col_data(col_data), .row_we(row_we), .row_addr(row_addr), .row_data(row_data),
        .nnz(nnz), .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct packed {logic [SA-1:0] a; logic [31:0] d; logic [31:0] c;} sp_t;
    typedef struct packed {logic [RA-1:0] a; logic [31:0] d;} rw_t;

    sp_t         sp_q[$];
    rw_t         rw_q[$];
    int          checks = 0, failures = 0, cyc = 0, t0 = 0, nnz_m = 0;
    logic [31:0] m [R][C];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sp_we) begin
            chk("sp_expected", 128'(sp_q.size() > 0), 128'(1));
            if (sp_q.size() > 0) chk("sp_write", {sp_addr, sp_data, col_data}, sp_q.pop_front());
        end
        if (row_we) begin
            chk("row_expected", 128'(rw_q.size() > 0), 128'(1));
            if (rw_q.size() > 0) chk("row_write", {row_addr, row_data}, rw_q.pop_front());
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        nnz_m = 0;
        rw_q.push_back('{a: '0, d: '0});
        @(posedge clk);
        #1 t0 = cyc;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int r, input int c, input bit st);
        int n;
        n = 0;
        din_data = v;
        din_valid = 1'b1;
        start = st;
        @(negedge clk);
        while (!din_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 128'(n < 20), 128'(1));
        if (v != 0 && nnz_m < 4) begin
            sp_q.push_back('{a: SA'(nnz_m), d: v, c: 32'(c)});
            nnz_m++;
        end
        if (c == C - 1) rw_q.push_back('{a: RA'(r + 1), d: 32'(nnz_m)});
        @(posedge clk);
        #1 din_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run(input bit gaps);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                if (gaps && $urandom_range(0, 2) == 0)
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                send(m[r][c], r, c, 1'b0);
            end
    endtask

    task automatic end_chk(input string tag, input int exp_nnz, input bit exp_ov);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_sp_left"}, 128'(sp_q.size()), 128'(0));
        chk({tag, "_row_left"}, 128'(rw_q.size()), 128'(0));
        chk({tag, "_nnz"}, 128'(nnz), 128'(exp_nnz));
        chk({tag, "_overflow"}, 128'(overflow), 128'(exp_ov));
        chk({tag, "_done_busy"}, 128'({done, busy}), 128'(2'b10));
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                m[r][c] = kind == 0 ? ((r == c) ? 32'd7 : 32'd0) :
                          kind == 1 ? 32'd0 :
                          kind == 2 ? ((r == 1) ? 32'(c + 1) : 32'd0) : 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", {din_ready, sp_we, sp_addr, sp_data, col_data, row_we, row_addr,
                                 row_data, nnz, busy, done, overflow}, '0);
        rst = 1'b1;

        fill(0);
        do_start();
        run(1'b0);
        chk("t1_done_now", 128'(done), 128'(1));
        chk("t1_latency", 128'(cyc - t0), 128'(17));
        end_chk("t1", 4, 1'b0);

        fill(1);
        do_start();
        run(1'b0);
        end_chk("t2", 0, 1'b0);

        fill(2);
        do_start();
        run(1'b1);
        end_chk("t3", 4, 1'b0);

        fill(3);
        do_start();
        for (int k = 0; k < R * C; k++) begin
            send(m[k / C][k % C], k / C, k % C, 1'b0);
            if (k == 3) chk("t4_ov_before", 128'(overflow), 128'(0));
            if (k == 4) chk("t4_ov_fifth", 128'(overflow), 128'(1));
        end
        end_chk("t4", 4, 1'b1);

        fill(0);
        do_start();
        @(posedge clk);
        #1 chk("t5_cleared", 128'({nnz, overflow, busy}), 128'({3'd0, 1'b0, 1'b1}));
        for (int k = 0; k < R * C; k++) send(m[k / C][k % C], k / C, k % C, k == 5);
        end_chk("t5", 4, 1'b0);

        do_start();
        for (int k = 0; k < 2 * C + 2; k++) send(m[k / C][k % C], k / C, k % C, 1'b0);
        rst = 1'b0;
        #1 chk("t6_reset_outputs", {din_ready, sp_we, sp_addr, sp_data, col_data, row_we, row_addr,
                                    row_data, nnz, busy, done, overflow}, '0);
        sp_q.delete();
        rw_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_start();
        run(1'b0);
        end_chk("t6", 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_encoder.md
Name: csr_encoder

Overview:
- Dense-to-CSR packer. Converts a row-major dense matrix stream into three CSR tables: nonzero values, column indices and row pointers.
- Fills the sparse-value, column-index and row-pointer RAMs that the SpMV multiplier later reads.
- Value and column RAMs share one write address. Row-pointer RAM has its own write port.
- Row pointer layout: rowptr[0]=0; rowptr[r+1] = cumulative nonzero count after row r.

Parameters:
- DATA_W, 32, element / value width
- ROWS, 560, matrix rows
- COLS, 560, matrix columns
- SP_AW, 14, value/column RAM address width; capacity 2^SP_AW entries
- ROW_AW, 10, row-pointer RAM address width; must satisfy ROWS+1 <= 2^ROW_AW

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a matrix; honoured only in IDLE or DONE
- din_data  in  DATA_W  dense element, row-major order
- din_valid  in  1  din_data valid
- din_ready  out  1  encoder accepts din_data
- sp_we  out  1  write strobe for value and column RAMs
- sp_addr  out  SP_AW  shared value/column write address
- sp_data  out  DATA_W  nonzero value
- col_data  out  32  column index, zero-extended
- row_we  out  1  row-pointer write strobe
- row_addr  out  ROW_AW  row-pointer write address
- row_data  out  32  row-pointer value, zero-extended nnz
- nnz  out  SP_AW+1  running nonzero count
- busy  out  1  high in INIT and STREAM
- done  out  1  high in DONE
- overflow  out  1  sticky; a nonzero was dropped

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs and internal counters = 0. Reset mid-matrix abandons the matrix; no further writes occur.
- State IDLE:
  - start -> INIT; clear nnz, overflow, row counter and column counter.
- State INIT (1 cycle):
  - Drive row_we=1, row_addr=0, row_data=0 -> STREAM.
- State STREAM:
  - din_ready=1. Accept = din_valid & din_ready.
  - On accept of a nonzero element with nnz < 2^SP_AW: next cycle sp_we=1, sp_addr=nnz (old value), sp_data=element, col_data=col; nnz increments. Write latency is 1 cycle.
  - On accept of a zero element: no sp write.
  - On accept of a nonzero element with nnz = 2^SP_AW: element is dropped, overflow set, nnz holds.
  - Every accept advances col. When col=COLS-1: col wraps to 0, row increments, and next cycle row_we=1, row_addr=row+1, row_data=nnz including the element just accepted. This write may coincide with an sp write; the ports are independent.
  - Accept of element (ROWS-1, COLS-1) -> DONE, after its sp and row writes are issued in the following cycle.
  - din_valid low stalls with no state change.
  - start is ignored.
- State DONE:
  - din_ready=0; done=1.
  - nnz and overflow hold.
  - start -> INIT, clearing counters.
- Output strobes:
  - sp_we and row_we are single-cycle registered pulses.
  - Address and data outputs hold their last written values between strobes.
- Overflow: sticky until next start or reset. Row pointers continue to be written using the saturated nnz.
- Completion: exactly ROWS+1 row-pointer writes per matrix. sp writes = min(nonzeros, 2^SP_AW).

Test Plan:
- ROWS=COLS=4. Stream identity*7 with continuous valid -> row writes (0,0),(1,1),(2,2),(3,3),(4,4); sp writes addr 0..3, data 7, col_data 0,1,2,3; done after 17 cycles past start.
- All-zero 4x4 -> no sp_we; five row writes all with data 0; nnz=0; done=1.
- Row 1 fully dense (values 1..4), other rows zero, random valid gaps -> rowptr = 0,0,4,4,4; sp addr 0..3, col_data 0..3; output identical to the no-gap run.
- SP_AW=2, 4x4 all ones -> exactly 4 sp writes; overflow=1 from the 5th nonzero; rowptr = 0,4,4,4,4; nnz=4.
- Assert rst low during row 2, then start a new matrix -> all outputs 0 while rst low; new run begins with row write (0,0) and sp_addr 0.
- start pulse during STREAM -> ignored. start in DONE -> rowptr[0] rewritten as 0; nnz and overflow cleared.
